multicycle_seq: RTL and testbench

MULTICYCLE_SEQ -- requirements
Module: multicycle_seq

---
 rtl/multicycle_seq_if.sv | 33 +++
 rtl/multicycle_seq.sv | 178 +++++++++++++++++
 tb/tb_multicycle_seq.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_seq_if.sv
// Sequencer-to-datapath/memory control bundle for multicycle_seq.
interface multicycle_seq_if;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       mem_sel_data;
    logic       ir_en;
    logic       pc_en;
    logic       rf_wr_en;

    modport master (
        input  opcode,
        input  mem_ready,
        output mem_req,
        output mem_we,
        output mem_sel_data,
        output ir_en,
        output pc_en,
        output rf_wr_en
    );

    modport slave (
        output opcode,
        output mem_ready,
        input  mem_req,
        input  mem_we,
        input  mem_sel_data,
        input  ir_en,
        input  pc_en,
        input  rf_wr_en
    );
endinterface

// File: rtl/multicycle_seq.sv
// Multicycle RV32-style control sequencer: FETCH/DECODE/EXEC/MEM/WB/TRAP.
// Optional memory-wait timeout trap enabled by macro MULTICYCLE_SEQ_TIMEOUT_EN.
module multicycle_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_seq_if.master  bus,
    output logic [2:0]        state,
    output logic [31:0]       instret,
    output logic              illegal,
    output logic              timeout
);

    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] instret_q, instret_d;
    logic        illegal_q, illegal_d;
    logic        is_legal;
    logic        tmo_hit;
    logic        mem_req_c, mem_we_c, mem_sel_c, ir_en_c, pc_en_c, rf_wr_en_c;

    // Opcode legality decode.
    always_comb begin
        is_legal = 1'b0;
        case (bus.opcode)
            OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_LUI,
            OP_AUIPC, OP_BR, OP_JAL, OP_JALR: is_legal = 1'b1;
            default: is_legal = 1'b0;
        endcase
    end

`ifdef MULTICYCLE_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;

    // Count consecutive stalled FETCH/MEM cycles; any other cycle clears it.
    always_comb begin
        tmo_cnt_d = '0;
        tmo_hit   = 1'b0;
        timeout_d = timeout_q;
        if ((state_q == S_FETCH || state_q == S_MEM) && !bus.mem_ready) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
            if (tmo_cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                tmo_hit   = 1'b1;
                tmo_cnt_d = '0;
                timeout_d = 1'b1;
            end
        end
    end

    // Timeout counter and sticky flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

    // Next-state and strobe decode from registered state plus inputs.
    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        mem_sel_c  = 1'b0;
        ir_en_c    = 1'b0;
        pc_en_c    = 1'b0;
        rf_wr_en_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (bus.mem_ready) begin
                    ir_en_c = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                if (bus.opcode == OP_LOAD || bus.opcode == OP_STORE) begin
                    state_d = S_MEM;
                end else if (bus.opcode == OP_BR) begin
                    pc_en_c = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                mem_sel_c = 1'b1;
                mem_we_c  = (bus.opcode == OP_STORE);
                if (bus.mem_ready) begin
                    if (bus.opcode == OP_STORE) begin
                        pc_en_c = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_wr_en_c = 1'b1;
                pc_en_c    = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        if (tmo_hit) begin
            state_d = S_TRAP;
        end
    end

    assign instret_d = pc_en_c ? instret_q + 32'd1 : instret_q;

    // State, retired count and illegal flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes are held low for the whole reset cycle.
    assign bus.mem_req      = mem_req_c  & ~rst;
    assign bus.mem_we       = mem_we_c   & ~rst;
    assign bus.mem_sel_data = mem_sel_c;
    assign bus.ir_en        = ir_en_c    & ~rst;
    assign bus.pc_en        = pc_en_c    & ~rst;
    assign bus.rf_wr_en     = rf_wr_en_c & ~rst;

    assign state   = 3'(state_q);
    assign instret = instret_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed, table-driven bench for multicycle_seq.
module tb_multicycle_seq;

    localparam logic [6:0] ALU = 7'b0110011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        rdy;
        logic [2:0]  st;
        logic        req;
        logic        we;
        logic        sel;
        logic        ir;
        logic        pc;
        logic        rf;
        logic [31:0] ins;
        logic        ill;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [2:0]  state;
    logic [31:0] instret;
    logic        illegal;
    logic        timeout;
    int          n_tests;
    int          n_fail;
    vec_t        tbl[$];

    multicycle_seq_if bus ();

    multicycle_seq #(.TIMEOUT_CYCLES(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state   (state),
        .instret (instret),
        .illegal (illegal),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [6:0] op, input logic rdy,
                                input logic [2:0] st, input logic req, input logic we,
                                input logic sel, input logic ir, input logic pc,
                                input logic rf, input logic [31:0] ins, input logic ill);
        vec_t v;
        v.rst = r;   v.op = op;   v.rdy = rdy; v.st = st;
        v.req = req; v.we = we;   v.sel = sel; v.ir = ir;
        v.pc = pc;   v.rf = rf;   v.ins = ins; v.ill = ill;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.opcode = ALU;
        bus.mem_ready = 1'b1;

        // rst op rdy | st req we sel ir pc rf instret illegal
        tbl.push_back(mk(1, ALU, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, ALU, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, ALU, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, ALU, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, ALU, 1, 4, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, BR,  1, 0, 1, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, BR,  1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, BR,  1, 2, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, ST,  1, 0, 1, 0, 0, 1, 0, 0, 2, 0));
        tbl.push_back(mk(0, ST,  1, 1, 0, 0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, ST,  1, 2, 0, 0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, ST,  0, 3, 1, 1, 1, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, ST,  1, 3, 1, 1, 1, 0, 1, 0, 2, 0));
        tbl.push_back(mk(0, LD,  0, 0, 1, 0, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, LD,  1, 0, 1, 0, 0, 1, 0, 0, 3, 0));
        tbl.push_back(mk(0, LD,  1, 1, 0, 0, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, LD,  1, 2, 0, 0, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, LD,  0, 3, 1, 0, 1, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, LD,  0, 3, 1, 0, 1, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, LD,  0, 3, 1, 0, 1, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, LD,  1, 3, 1, 0, 1, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, LD,  1, 4, 0, 0, 0, 0, 1, 1, 3, 0));
        tbl.push_back(mk(0, JAL, 1, 0, 1, 0, 0, 1, 0, 0, 4, 0));
        tbl.push_back(mk(0, JAL, 1, 1, 0, 0, 0, 0, 0, 0, 4, 0));
        tbl.push_back(mk(0, JAL, 1, 2, 0, 0, 0, 0, 0, 0, 4, 0));
        tbl.push_back(mk(0, JAL, 1, 4, 0, 0, 0, 0, 1, 1, 4, 0));
        tbl.push_back(mk(0, BAD, 1, 0, 1, 0, 0, 1, 0, 0, 5, 0));
        tbl.push_back(mk(0, BAD, 1, 1, 0, 0, 0, 0, 0, 0, 5, 0));
        tbl.push_back(mk(0, BAD, 1, 5, 0, 0, 0, 0, 0, 0, 5, 1));
        tbl.push_back(mk(0, BAD, 0, 5, 0, 0, 0, 0, 0, 0, 5, 1));
        tbl.push_back(mk(1, BAD, 0, 5, 0, 0, 0, 0, 0, 0, 5, 1));
        tbl.push_back(mk(0, ST,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, ST,  1, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, ST,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, ST,  1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, ST,  0, 3, 1, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, ST,  0, 3, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, ST,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst           = tbl[i].rst;
            bus.opcode    = tbl[i].op;
            bus.mem_ready = tbl[i].rdy;
            #2;
            check($sformatf("row%0d_state", i),   32'(state),            32'(tbl[i].st));
            check($sformatf("row%0d_mem_req", i), 32'(bus.mem_req),      32'(tbl[i].req));
            check($sformatf("row%0d_mem_we", i),  32'(bus.mem_we),       32'(tbl[i].we));
            check($sformatf("row%0d_sel", i),     32'(bus.mem_sel_data), 32'(tbl[i].sel));
            check($sformatf("row%0d_ir_en", i),   32'(bus.ir_en),        32'(tbl[i].ir));
            check($sformatf("row%0d_pc_en", i),   32'(bus.pc_en),        32'(tbl[i].pc));
            check($sformatf("row%0d_rf_wr", i),   32'(bus.rf_wr_en),     32'(tbl[i].rf));
            check($sformatf("row%0d_instret", i), instret,               tbl[i].ins);
            check($sformatf("row%0d_illegal", i), 32'(illegal),          32'(tbl[i].ill));
            check($sformatf("row%0d_timeout", i), 32'(timeout),          32'd0);
        end

        // Stalled fetch: timeout trap when enabled, unbounded hold otherwise.
        reset_dut();
`ifdef MULTICYCLE_SEQ_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            #2;
            check($sformatf("tmo_wait%0d_state", i), 32'(state), 32'd0);
            @(negedge clk);
        end
        #2;
        check("tmo_state", 32'(state), 32'd5);
        check("tmo_flag", 32'(timeout), 32'd1);
        check("tmo_mem_req", 32'(bus.mem_req), 32'd0);
        check("tmo_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #2;
        check("tmo_sticky_state", 32'(state), 32'd5);
        check("tmo_sticky_flag", 32'(timeout), 32'd1);
`else
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
        end
        #2;
        check("hold100_state", 32'(state), 32'd0);
        check("hold100_mem_req", 32'(bus.mem_req), 32'd1);
        check("hold100_timeout", 32'(timeout), 32'd0);
`endif

        // instret wrap: preload all-ones, retire one branch.
        reset_dut();
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        check("wrap_preload", instret, 32'hFFFF_FFFF);
        @(negedge clk);
        bus.opcode    = BR;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        check("wrap_exec_pc_en", 32'(bus.pc_en), 32'd1);
        check("wrap_exec_before", instret, 32'hFFFF_FFFF);
        @(negedge clk);
        #2;
        check("wrap_instret", instret, 32'd0);
        check("wrap_state", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
